// File: rtl/div_sequencer.sv
// div_sequencer: iterative radix-2 restoring divide/remainder unit for the Execute stage.
// Ports: clk/reset (async, active-high); StartE/FlushE/OpE/SrcAE/SrcBE/RdE in from E;
//        BusyE (combinational stall request), DoneE (1-cycle result strobe), ResultE, RdDivE out.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StartE,
  input  logic            FlushE,
  input  logic [1:0]      OpE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic [4:0]      RdE,
  output logic            BusyE,
  output logic            DoneE,
  output logic [XLEN-1:0] ResultE,
  output logic [4:0]      RdDivE
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;

  state_t state, state_n;

  // Captured operation
  logic [1:0]      op_q;
  logic [4:0]      rd_q;
  logic            neg_a, neg_b;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] quo;
  // After every restoring step the partial remainder is below |B|, so it
  // always fits in XLEN bits; only the shifted working value needs XLEN+1.
  logic [XLEN-1:0] rem;
  logic [CW-1:0]   cnt;

  // Accept-side decode
  logic            accept;
  logic            is_signed;
  logic            a_neg_in, b_neg_in;
  logic [XLEN-1:0] a_mag_in, b_mag_in;
  logic            div_zero, ovf, early;
  logic [XLEN-1:0] early_res;

  assign accept    = (state == IDLE) & StartE & ~FlushE;
  assign is_signed = ~OpE[0];
  assign a_neg_in  = is_signed & SrcAE[XLEN-1];
  assign b_neg_in  = is_signed & SrcBE[XLEN-1];
  assign a_mag_in  = a_neg_in ? -SrcAE : SrcAE;
  assign b_mag_in  = b_neg_in ? -SrcBE : SrcBE;
  assign div_zero  = (SrcBE == '0);
  assign ovf       = is_signed & (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) & (SrcBE == '1);
  assign early     = div_zero | ovf;

  // Early-out results; OpE[1] selects remainder.
  always_comb begin
    early_res = '0;
    if (div_zero)
      early_res = OpE[1] ? SrcAE : '1;
    else
      early_res = OpE[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // One restoring step
  logic [XLEN:0]   rem_sh;
  logic            rem_ge;
  logic [XLEN-1:0] rem_sub;
  logic            last_step;

  assign rem_sh    = {rem, quo[XLEN-1]};
  assign rem_ge    = rem_sh >= {1'b0, b_mag};
  // True difference is below 2^XLEN whenever it is taken, so the low bits suffice.
  assign rem_sub   = rem_sh[XLEN-1:0] - b_mag;
  assign last_step = (cnt == CW'(XLEN - 1));

  // Sign correction
  logic [XLEN-1:0] quo_fix, rem_fix;
  assign quo_fix = (neg_a ^ neg_b) ? -quo : quo;
  assign rem_fix = neg_a ? -rem : rem;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state and control outputs
  always_comb begin
    state_n = state;
    BusyE   = 1'b0;
    DoneE   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = early ? DONE : RUN;
          BusyE   = 1'b1;
        end
      end
      RUN: begin
        BusyE = 1'b1;
        if (FlushE)         state_n = IDLE;
        else if (last_step) state_n = FIXUP;
      end
      FIXUP: begin
        BusyE   = 1'b1;
        state_n = FlushE ? IDLE : DONE;
      end
      DONE: begin
        // Same instruction is still in E here, so StartE is not a new op.
        DoneE   = ~FlushE;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Keep the stall request low while reset is held, even with StartE up.
    if (reset) BusyE = 1'b0;
  end

  // Datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= '0;
      rd_q    <= '0;
      neg_a   <= 1'b0;
      neg_b   <= 1'b0;
      b_mag   <= '0;
      quo     <= '0;
      rem     <= '0;
      cnt     <= '0;
      ResultE <= '0;
      RdDivE  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= OpE;
            rd_q  <= RdE;
            neg_a <= a_neg_in;
            neg_b <= b_neg_in;
            b_mag <= b_mag_in;
            quo   <= a_mag_in;
            rem   <= '0;
            cnt   <= '0;
            if (early) begin
              ResultE <= early_res;
              RdDivE  <= RdE;
            end
          end
        end
        RUN: begin
          if (!FlushE) begin
            if (rem_ge) begin
              rem <= rem_sub;
              quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
              rem <= rem_sh[XLEN-1:0];
              quo <= {quo[XLEN-2:0], 1'b0};
            end
            cnt <= cnt + CW'(1);
          end
        end
        FIXUP: begin
          // A flushed op leaves the previous result in place.
          if (!FlushE) begin
            ResultE <= op_q[1] ? rem_fix : quo_fix;
            RdDivE  <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed self-checking bench for div_sequencer (XLEN=32).
// Drives inputs 1ns after the rising edge, samples outputs on the falling edge.
// Ports: none; instantiates div_sequencer with every port connected.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        StartE;
  logic        FlushE;
  logic [1:0]  OpE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic [4:0]  RdE;
  logic        BusyE;
  logic        DoneE;
  logic [31:0] ResultE;
  logic [4:0]  RdDivE;

  int vectors     = 0;
  int miscompares = 0;

  div_sequencer #(.XLEN(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .StartE  (StartE),
    .FlushE  (FlushE),
    .OpE     (OpE),
    .SrcAE   (SrcAE),
    .SrcBE   (SrcBE),
    .RdE     (RdE),
    .BusyE   (BusyE),
    .DoneE   (DoneE),
    .ResultE (ResultE),
    .RdDivE  (RdDivE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op at cycle 0 (caller is 1ns after a rising edge), wait for DoneE,
  // then check latency, stall length, result and Rd. Returns 1ns after the edge
  // that follows the DONE cycle, so a following call is back-to-back.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat);
    int cyc      = 0;
    int busy_cnt = 0;
    bit seen     = 1'b0;
    StartE = 1'b1;
    OpE    = op;
    SrcAE  = a;
    SrcBE  = b;
    RdE    = rd;
    @(negedge clk);
    check({tag, "/busy_c0"}, 32'(BusyE), 32'd1);
    check({tag, "/done_c0"}, 32'(DoneE), 32'd0);
    if (BusyE) busy_cnt++;
    while (!seen && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        // Operands change under a held StartE; the captured op must not.
        OpE   = ~op;
        SrcAE = ~a;
        SrcBE = ~b;
        RdE   = ~rd;
      end
      @(negedge clk);
      if (DoneE) seen = 1'b1;
      else if (BusyE) busy_cnt++;
    end
    check({tag, "/done_cycle"}, 32'(cyc), 32'(exp_lat));
    check({tag, "/busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    check({tag, "/busy_in_done"}, 32'(BusyE), 32'd0);
    check({tag, "/result"}, ResultE, exp);
    check({tag, "/rd"}, 32'(RdDivE), 32'(rd));
    @(posedge clk);
    #1;
    StartE = 1'b0;
  endtask

  initial begin
    int dn;
    reset  = 1'b1;
    StartE = 1'b0;
    FlushE = 1'b0;
    OpE    = 2'b00;
    SrcAE  = '0;
    SrcBE  = '0;
    RdE    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset/busy",   32'(BusyE),  32'd0);
    check("reset/done",   32'(DoneE),  32'd0);
    check("reset/result", ResultE,     32'd0);
    check("reset/rd",     32'(RdDivE), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Normal path
    run_op("divu_100_7",   2'b01, 32'd100,       32'd7,         5'd3, 32'd14,        34);
    run_op("remu_100_7",   2'b11, 32'd100,       32'd7,         5'd4, 32'd2,         34);
    run_op("div_m7_2",     2'b00, 32'hFFFFFFF9,  32'd2,         5'd5, 32'hFFFFFFFD,  34);
    run_op("rem_m7_2",     2'b10, 32'hFFFFFFF9,  32'd2,         5'd6, 32'hFFFFFFFF,  34);
    run_op("div_7_m2",     2'b00, 32'd7,         32'hFFFFFFFE,  5'd7, 32'hFFFFFFFD,  34);
    run_op("divu_min_ff",  2'b01, 32'h80000000,  32'hFFFFFFFF,  5'd9, 32'd0,         34);

    // Early-out path
    run_op("divu_5_0",     2'b01, 32'd5,         32'd0,         5'd13, 32'hFFFFFFFF, 1);
    run_op("remu_5_0",     2'b11, 32'd5,         32'd0,         5'd14, 32'd5,        1);
    run_op("div_min_m1",   2'b00, 32'h80000000,  32'hFFFFFFFF,  5'd15, 32'h80000000, 1);
    run_op("rem_min_m1",   2'b10, 32'h80000000,  32'hFFFFFFFF,  5'd16, 32'd0,        1);
    run_op("rem_m7_0",     2'b10, 32'hFFFFFFF9,  32'd0,         5'd17, 32'hFFFFFFF9, 1);

    // Flush in cycle 10 of a DIVU 100/7
    dn     = 0;
    StartE = 1'b1;
    OpE    = 2'b01;
    SrcAE  = 32'd100;
    SrcBE  = 32'd7;
    RdE    = 5'd18;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (DoneE) dn++;
      @(posedge clk);
      #1;
    end
    FlushE = 1'b1;
    @(negedge clk);
    check("flush/busy_c10", 32'(BusyE), 32'd1);
    if (DoneE) dn++;
    @(posedge clk);
    #1;
    FlushE = 1'b0;
    StartE = 1'b0;
    @(negedge clk);
    check("flush/busy_c11", 32'(BusyE), 32'd0);
    check("flush/no_done",  32'(dn + int'(DoneE)), 32'd0);
    check("flush/result_held", ResultE, 32'hFFFFFFF9);
    check("flush/rd_held",  32'(RdDivE), 32'd17);
    @(posedge clk);
    #1;
    run_op("divu_9_3_after_flush", 2'b01, 32'd9, 32'd3, 5'd19, 32'd3, 34);

    // Asynchronous reset in cycle 20 of a run, StartE still high
    StartE = 1'b1;
    OpE    = 2'b01;
    SrcAE  = 32'd100;
    SrcBE  = 32'd7;
    RdE    = 5'd20;
    repeat (20) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("areset/busy",   32'(BusyE),  32'd0);
    check("areset/done",   32'(DoneE),  32'd0);
    check("areset/result", ResultE,     32'd0);
    check("areset/rd",     32'(RdDivE), 32'd0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    StartE = 1'b0;
    @(posedge clk);
    #1;
    run_op("divu_8_2_after_reset", 2'b01, 32'd8, 32'd2, 5'd21, 32'd4, 34);

    // Back-to-back
    run_op("b2b_divu_10_3", 2'b01, 32'd10, 32'd3, 5'd22, 32'd3, 34);
    run_op("b2b_remu_10_3", 2'b11, 32'd10, 32'd3, 5'd23, 32'd1, 34);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
